// File: rtl/ip_timing_sequencer_pkg.sv
// Shared types and constants for the machine-cycle timing sequencer.
package ip_timing_pkg;

   // Eight subcycles of one instruction cycle, in execution order.
   typedef enum logic [2:0] {
      SUB_A1 = 3'd0,
      SUB_A2 = 3'd1,
      SUB_A3 = 3'd2,
      SUB_M1 = 3'd3,
      SUB_M2 = 3'd4,
      SUB_X1 = 3'd5,
      SUB_X2 = 3'd6,
      SUB_X3 = 3'd7
   } sub_e;

   // Tick positions of the two sub-phase enables inside a subcycle.
   localparam int CLK1_TICK = 0;
   localparam int CLK2_TICK = 2;

   // Single-cycle / second-cycle state of the current instruction.
   typedef enum logic {
      ST_SC1 = 1'b0,
      ST_DC2 = 1'b1
   } sc_state_e;

endpackage

// File: rtl/ip_timing_sequencer_phase_divider.sv
// Tick counter producing registered clk1/clk2 enables and the
// subcycle-advance pulse for the sequencer.
module phase_divider
   import ip_timing_pkg::*;
#(
   parameter int TICKS_PER_SUB = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk1,
   output logic clk2,
   output logic adv,       // the coming edge starts a new subcycle
   output logic clk2_nxt   // the coming edge is a clk2 tick
);

   localparam int TW = $clog2(TICKS_PER_SUB);
   localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_SUB - 1);
   localparam logic [TW-1:0] C1_TICK   = TW'(CLK1_TICK);
   localparam logic [TW-1:0] C2_TICK   = TW'(CLK2_TICK);

   // tick_q holds the tick index that becomes visible on the next edge.
   // started_q suppresses the subcycle advance on the very first edge,
   // which lands on tick 0 of A1 rather than leaving it.
   logic [TW-1:0] tick_q, tick_d;
   logic          started_q, started_d;
   logic          clk1_q, clk1_d;
   logic          clk2_q, clk2_d;

   // Next tick and the enables registered for it.
   always_comb begin
      tick_d    = (tick_q == LAST_TICK) ? '0 : tick_q + TW'(1);
      started_d = 1'b1;
      clk1_d    = (tick_q == C1_TICK);
      clk2_d    = (tick_q == C2_TICK);
   end

   // Counter and enable registers; enables are cleared in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q    <= '0;
         started_q <= 1'b0;
         clk1_q    <= 1'b0;
         clk2_q    <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         started_q <= started_d;
         clk1_q    <= clk1_d;
         clk2_q    <= clk2_d;
      end
   end

   assign clk1     = clk1_q;
   assign clk2     = clk2_q;
   assign adv      = started_q & (tick_q == '0);
   assign clk2_nxt = (tick_q == C2_TICK);

endmodule

// File: rtl/ip_timing_sequencer.sv
// Machine timing sequencer: subcycle levels, SYNC, sc/dc state,
// power-on-clear window and incrementer load strobe. All outputs are flops.
module ip_timing_sequencer
   import ip_timing_pkg::*;
#(
   parameter int TICKS_PER_SUB = 4,
   parameter int POC_CYCLES    = 2
) (
   input  logic sysclk,
   input  logic poc_n,
   input  logic two_word,
   output logic clk1,
   output logic clk2,
   output logic a12,
   output logic a22,
   output logic a32,
   output logic m12,
   output logic m22,
   output logic x12,
   output logic x22,
   output logic x32,
   output logic sync,
   output logic sc,
   output logic dc,
   output logic poc,
   output logic incr_load
);

   localparam int CW = $clog2(POC_CYCLES + 1);

   logic      adv, clk2_nxt, wrap, sample;
   sub_e      sub_q, sub_d;
   logic [7:0] lvl_q, lvl_d;
   sc_state_e state_q, state_d;
   logic      pend_q, pend_d;
   logic      poc_q, poc_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic      incr_q, incr_d;

   phase_divider #(.TICKS_PER_SUB(TICKS_PER_SUB)) u_phase (
      .clk      (sysclk),
      .rst_n    (poc_n),
      .clk1     (clk1),
      .clk2     (clk2),
      .adv      (adv),
      .clk2_nxt (clk2_nxt)
   );

   // X3->A1 boundary on the coming edge.
   assign wrap = adv & (sub_q == SUB_X3);
   // two_word is only looked at on the M2 clk2 tick of a first cycle, after POC.
   assign sample = clk2 & (sub_q == SUB_M2) & (state_q == ST_SC1) & ~poc_q;

   // Next subcycle, sc/dc state, POC window and load strobe.
   always_comb begin
      sub_d   = sub_q;
      lvl_d   = lvl_q;
      state_d = state_q;
      pend_d  = pend_q;
      poc_d   = poc_q;
      cyc_d   = cyc_q;
      incr_d  = clk2_nxt & ((sub_q == SUB_A1) | (sub_q == SUB_A2) | (sub_q == SUB_A3));

      if (adv) begin
         sub_d = sub_e'(sub_q + 3'd1);
      end
      lvl_d = 8'd1 << sub_d;

      if (sample) begin
         pend_d = two_word;
      end

      if (wrap) begin
         pend_d = 1'b0;
         case (state_q)
            ST_SC1:  state_d = pend_q ? ST_DC2 : ST_SC1;
            ST_DC2:  state_d = ST_SC1;
            default: state_d = ST_SC1;
         endcase
         if (poc_q) begin
            cyc_d = cyc_q + CW'(1);
            if (cyc_d == CW'(POC_CYCLES)) begin
               poc_d = 1'b0;
            end
         end
      end
   end

   // State registers; reset parks the machine in A1 of a first cycle with POC open.
   always_ff @(posedge sysclk or negedge poc_n) begin
      if (!poc_n) begin
         sub_q   <= SUB_A1;
         lvl_q   <= 8'd1;
         state_q <= ST_SC1;
         pend_q  <= 1'b0;
         poc_q   <= 1'b1;
         cyc_q   <= '0;
         incr_q  <= 1'b0;
      end else begin
         sub_q   <= sub_d;
         lvl_q   <= lvl_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         poc_q   <= poc_d;
         cyc_q   <= cyc_d;
         incr_q  <= incr_d;
      end
   end

   assign a12       = lvl_q[0];
   assign a22       = lvl_q[1];
   assign a32       = lvl_q[2];
   assign m12       = lvl_q[3];
   assign m22       = lvl_q[4];
   assign x12       = lvl_q[5];
   assign x22       = lvl_q[6];
   assign x32       = lvl_q[7];
   assign sync      = lvl_q[7];
   assign sc        = (state_q == ST_SC1);
   assign dc        = (state_q == ST_DC2);
   assign poc       = poc_q;
   assign incr_load = incr_q;

endmodule

// File: doc/ip_timing_sequencer.md
Name: ip_timing_sequencer

Overview:
- Generates the 8-subcycle machine timing (A1 A2 A3 M1 M2 X1 X2 X3) and the clk1/clk2 sub-phase enables from sysclk.
- Owns the single-cycle/double-cycle state (sc/dc), the SYNC pulse and the power-on-clear window.
- Drives the strobes that sequence the instruction pointer array, its incrementer and the address-pointer stepping.
- Sits between the top-level clock/reset and the instruction pointer and decoder blocks.

Parameters:
- TICKS_PER_SUB, 4, sysclk ticks per subcycle; minimum 4. clk1 is on tick 0, clk2 on tick 2, other ticks idle.
- POC_CYCLES, 2, full instruction cycles during which poc stays high after reset release.

Ports:
- sysclk  in  1  system clock; all state advances on the rising edge
- poc_n  in  1  asynchronous active-low reset
- two_word  in  1  decoder: current opcode is a two-word instruction; sampled at the M2 clk2 tick
- clk1  out  1  one-tick phase-1 enable
- clk2  out  1  one-tick phase-2 enable
- a12, a22, a32, m12, m22, x12, x22, x32  out  1 each  subcycle levels, high for the whole subcycle (A1..X3 respectively)
- sync  out  1  high for the whole X3 subcycle
- sc  out  1  high in the first (or only) cycle of an instruction
- dc  out  1  ~sc
- poc  out  1  power-on clear, high while the POC window is open
- incr_load  out  1  clk2 tick of A1, A2 or A3: the incrementer captures the nibble on the data bus

Behaviour:
- Counters: tick counter 0..TICKS_PER_SUB-1 and subcycle counter 0..7, both wrapping. The subcycle counter advances when the tick counter wraps.
- clk1 = (tick==0). clk2 = (tick==2). These are never high together, and each is a single tick per subcycle.
- Subcycle levels are registered decodes: exactly one of a12..x32 is high at all times after reset. X3 wraps to A1.
- sync = x32.
- sc/dc state machine (states SC1, DC2):
  - In SC1, at the M2 clk2 tick: if two_word=1, go to DC2 at the X3→A1 boundary; otherwise stay in SC1.
  - In DC2, always return to SC1 at the next X3→A1 boundary.
  - two_word is ignored while in DC2, so a second two_word never chains a third cycle.
  - sc changes only at the X3→A1 boundary, so it is stable for a whole instruction cycle.
- POC:
  - A cycle counter counts X3→A1 wraps after reset release.
  - poc = 1 until POC_CYCLES wraps have occurred, then 0 permanently until the next reset.
  - two_word is ignored while poc=1, and sc is forced to 1.
- Reset (poc_n=0, asynchronous, may arrive mid-subcycle):
  - tick=0, subcycle=A1, so a12=1 and the other levels are 0.
  - clk1 and clk2 are 0 while in reset.
  - sc=1, dc=0, poc=1, sync=0, incr_load=0.
- First edge after reset release:
  - tick 0 of A1, so clk1 is high on the first active edge.
  - All outputs must be glitch-free registered values; no combinational path from two_word to any output.
- Latency: levels change on the edge where tick wraps to 0; clk1 is therefore coincident with the first tick of each new subcycle.
- incr_load = clk2 & (a12 | a22 | a32).

Decomposition:
- Shared package ip_timing_pkg:
  - subcycle enum SUB_A1..SUB_X3 (3-bit, encoded 0..7)
  - tick constants CLK1_TICK=0, CLK2_TICK=2
  - sc state enum ST_SC1/ST_DC2
- Single natural sub-module phase_divider: tick counter plus clk1/clk2 generation and a subcycle-advance pulse.
- The top level holds the subcycle decode, the sc FSM and the POC counter.

Test Plan:
- Release reset, run 3 instruction cycles at TICKS_PER_SUB=4:
  - each cycle is 32 sysclk ticks
  - clk1 and clk2 pulse 8 times per cycle; clk1 on ticks 0,4,…,28 and clk2 on ticks 2,6,…,30
  - a12..x32 are one-hot, in order A1..X3
  - sync is high on ticks 28–31
- POC window:
  - poc=1 for exactly the first 64 ticks, with two_word=1 asserted throughout
  - sc stays 1 during that window
  - poc falls at the A1 boundary of cycle 2
- two_word=1 at M2 clk2 in cycle N (poc=0):
  - sc=0, dc=1 for the whole of cycle N+1
  - sc=1 again in N+2, even with two_word held at 1
- two_word pulse outside M2 clk2 (for example during X1) → sc unaffected.
- Assert poc_n=0 asynchronously mid-M1 at tick 2 of the subcycle:
  - outputs take reset values immediately, without waiting for an edge
  - on release, sequencing restarts at A1 tick 0 and the POC window restarts
- Check incr_load: exactly 3 single-tick pulses per cycle, at ticks 2, 6 and 10.
